// File: rtl/cpu6_pipeline_drain_ctrl_if.sv
// Bus between the hazard unit's pipeline-drain responder and the E-stage/LSU side.
// The master is the pipeline side and the slave is the drain controller.
interface cpu6_pipeline_drain_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            empty_pipeline_reqE;
  logic [XLEN-1:0] pcE;
  logic            ex_stall;
  logic            redirect;
  logic            lsu_busy;
  logic            stall_fd;
  logic            flash_idex;
  logic            drain_busy;
  logic            drained;
  logic [XLEN-1:0] drained_pc;
  logic            drain_timeout;

  modport master (
    output empty_pipeline_reqE, pcE, ex_stall, redirect, lsu_busy,
    input  stall_fd, flash_idex, drain_busy, drained, drained_pc, drain_timeout
  );

  modport slave (
    input  empty_pipeline_reqE, pcE, ex_stall, redirect, lsu_busy,
    output stall_fd, flash_idex, drain_busy, drained, drained_pc, drain_timeout
  );
endinterface

// File: rtl/cpu6_pipeline_drain_ctrl.sv
// Empty-pipeline responder: stalls F/D and flashes ID/EX until the stages after E and the LSU
// are quiet, then pulses drained; a later-stage redirect aborts the drain.
module cpu6_pipeline_drain_ctrl #(
  parameter int unsigned STAGES_AFTER_E = 2,
  parameter int unsigned CNT_W          = 2,
  parameter int unsigned TIMEOUT        = 64,
  parameter int unsigned TO_W           = 7,
  parameter int unsigned XLEN           = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  cpu6_pipeline_drain_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    WAIT_MEM = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic [XLEN-1:0]   drained_pc_q, drained_pc_d;

  logic accept;
  logic active;
  logic timeout_hit;

  // accept is gated by reset so the Mealy outputs also drop the instant reset rises
  assign accept      = (state_q == IDLE) & bus.empty_pipeline_reqE & ~bus.ex_stall
                       & ~bus.redirect & ~reset;
  assign active      = (state_q != IDLE);
  assign timeout_hit = (state_q == WAIT_MEM) & ~bus.redirect & bus.lsu_busy
                       & (tcnt_q == TO_W'(TIMEOUT - 1));

  // Redirect releases F/D at once so fetch can take the new PC, but keeps bubbling E
  assign bus.stall_fd      = accept | (active & ~bus.redirect & (state_q != DONE));
  assign bus.flash_idex    = accept | (active & ((state_q != DONE) | bus.redirect));
  assign bus.drain_busy    = active;
  assign bus.drained       = (state_q == DONE) & ~bus.redirect;
  assign bus.drain_timeout = timeout_hit;
  assign bus.drained_pc    = drained_pc_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    drained_pc_d = drained_pc_q;

    if (active && bus.redirect) begin
      state_d = IDLE;
      cnt_d   = '0;
      tcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d      = DRAIN;
            cnt_d        = CNT_W'(STAGES_AFTER_E);
            drained_pc_d = bus.pcE;
          end
        end
        DRAIN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            tcnt_d  = '0;
            state_d = bus.lsu_busy ? WAIT_MEM : DONE;
          end
        end
        WAIT_MEM: begin
          if (!bus.lsu_busy) begin
            state_d = DONE;
            tcnt_d  = '0;
          end else if (timeout_hit) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TO_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
          tcnt_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      drained_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      drained_pc_q <= drained_pc_d;
    end
  end

endmodule

// File: tb/tb_cpu6_pipeline_drain_ctrl.sv
// Directed bench for cpu6_pipeline_drain_ctrl: per-cycle input/expected-output tables per scenario.
module tb_cpu6_pipeline_drain_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cpu6_pipeline_drain_ctrl_if #(.XLEN(32)) bus ();

  cpu6_pipeline_drain_ctrl #(
    .STAGES_AFTER_E(2),
    .CNT_W(2),
    .TIMEOUT(64),
    .TO_W(7),
    .XLEN(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // {stall_fd, flash_idex, drain_busy, drained, drain_timeout}
  function automatic logic [4:0] obs();
    return {bus.stall_fd, bus.flash_idex, bus.drain_busy, bus.drained, bus.drain_timeout};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic exs, input logic rd, input logic lsu,
                       input logic [31:0] pc);
    bus.empty_pipeline_reqE = req;
    bus.ex_stall            = exs;
    bus.redirect            = rd;
    bus.lsu_busy            = lsu;
    bus.pcE                 = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #3;
    vectors++;
    if (obs() !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want %b", obs(), 5'b00000);
    end
    vectors++;
    if (bus.drained_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_pc: got %h want %h", bus.drained_pc, 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    logic [4:0] e [5] = '{5'b11000, 5'b11100, 5'b11100, 5'b00110, 5'b00000};
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      drive(c == 0, 1'b0, 1'b0, 1'b0, (c == 0) ? 32'h100 : 32'h0);
      @(negedge clk);
      vectors++;
      if (obs() !== e[c]) begin
        miscompares++;
        $display("FAIL nominal c%0d: got %b want %b", c, obs(), e[c]);
      end
      if (c == 3) begin
        vectors++;
        if (bus.drained_pc !== 32'h100) begin
          miscompares++;
          $display("FAIL nominal_pc: got %h want %h", bus.drained_pc, 32'h100);
        end
      end
    end
  endtask

  task automatic test_lsu_wait();
    logic [4:0] e [9] = '{5'b11000, 5'b11100, 5'b11100, 5'b11100, 5'b11100,
                          5'b11100, 5'b11100, 5'b00110, 5'b00000};
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      drive(c == 0, 1'b0, 1'b0, c <= 5, (c == 0) ? 32'h200 : 32'h0);
      @(negedge clk);
      vectors++;
      if (obs() !== e[c]) begin
        miscompares++;
        $display("FAIL lsu_wait c%0d: got %b want %b", c, obs(), e[c]);
      end
      if (c == 7) begin
        vectors++;
        if (bus.drained_pc !== 32'h200) begin
          miscompares++;
          $display("FAIL lsu_wait_pc: got %h want %h", bus.drained_pc, 32'h200);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [4:0] ex;
    int         n_to = 0;
    for (int c = 0; c < 68; c++) begin
      next_cycle();
      drive(c == 0, 1'b0, 1'b0, 1'b1, (c == 0) ? 32'h300 : 32'h0);
      if (c == 0)       ex = 5'b11000;
      else if (c < 66)  ex = 5'b11100;
      else if (c == 66) ex = 5'b11101;
      else              ex = 5'b00000;
      @(negedge clk);
      if (bus.drain_timeout === 1'b1) n_to++;
      vectors++;
      if (obs() !== ex) begin
        miscompares++;
        $display("FAIL timeout c%0d: got %b want %b", c, obs(), ex);
      end
    end
    vectors++;
    if (n_to != 1) begin
      miscompares++;
      $display("FAIL timeout_pulses: got %0d want 1", n_to);
    end
    vectors++;
    if (bus.drained_pc !== 32'h300) begin
      miscompares++;
      $display("FAIL timeout_pc: got %h want %h", bus.drained_pc, 32'h300);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_redirect();
    logic        rq [9] = '{1, 1, 0, 0, 1, 0, 0, 0, 0};
    logic        rd [9] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
    logic [31:0] pc [9] = '{32'h3F0, 32'h400, 0, 0, 32'h500, 0, 0, 0, 0};
    logic [4:0]  e  [9] = '{5'b00000, 5'b11000, 5'b11100, 5'b01100, 5'b11000,
                            5'b11100, 5'b11100, 5'b00110, 5'b00000};
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      drive(rq[c], 1'b0, rd[c], 1'b0, pc[c]);
      @(negedge clk);
      vectors++;
      if (obs() !== e[c]) begin
        miscompares++;
        $display("FAIL redirect c%0d: got %b want %b", c, obs(), e[c]);
      end
      if (c == 4) begin
        vectors++;
        if (bus.drained_pc !== 32'h400) begin
          miscompares++;
          $display("FAIL redirect_pc_kept: got %h want %h", bus.drained_pc, 32'h400);
        end
      end
      if (c == 7) begin
        vectors++;
        if (bus.drained_pc !== 32'h500) begin
          miscompares++;
          $display("FAIL redirect_pc_new: got %h want %h", bus.drained_pc, 32'h500);
        end
      end
    end
  endtask

  task automatic test_ex_stall();
    logic [4:0] e [9] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11000,
                          5'b11100, 5'b11100, 5'b00110, 5'b00000};
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      drive(c <= 4, c <= 3, 1'b0, 1'b0, (c <= 4) ? 32'h600 : 32'h0);
      @(negedge clk);
      vectors++;
      if (obs() !== e[c]) begin
        miscompares++;
        $display("FAIL ex_stall c%0d: got %b want %b", c, obs(), e[c]);
      end
      if (c == 7) begin
        vectors++;
        if (bus.drained_pc !== 32'h600) begin
          miscompares++;
          $display("FAIL ex_stall_pc: got %h want %h", bus.drained_pc, 32'h600);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] e [4] = '{5'b11000, 5'b11100, 5'b11100, 5'b11100};
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive(c == 0, 1'b0, 1'b0, 1'b1, (c == 0) ? 32'h700 : 32'h0);
      @(negedge clk);
      vectors++;
      if (obs() !== e[c]) begin
        miscompares++;
        $display("FAIL async_pre c%0d: got %b want %b", c, obs(), e[c]);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (obs() !== 5'b00000) begin
      miscompares++;
      $display("FAIL async_outputs: got %b want %b", obs(), 5'b00000);
    end
    vectors++;
    if (bus.drained_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL async_pc: got %h want %h", bus.drained_pc, 32'h0);
    end
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    vectors++;
    if (obs() !== 5'b00000) begin
      miscompares++;
      $display("FAIL async_idle: got %b want %b", obs(), 5'b00000);
    end
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h800);
    @(negedge clk);
    vectors++;
    if (obs() !== 5'b11000) begin
      miscompares++;
      $display("FAIL async_reaccept: got %b want %b", obs(), 5'b11000);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lsu_wait();
    test_timeout();
    test_redirect();
    test_ex_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
